// File: rtl/match_timer_display_pkg.sv
// Shared definitions for the match timer: FSM states, glyph geometry and BCD helpers.
package match_timer_display_pkg;

    typedef enum logic [1:0] {
        ST_SET     = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int GLYPH_W = 25;
    localparam int GLYPH_H = 40;
    localparam int SEG_T   = 5;
    localparam int DIGIT_W = 4;

    // Elaboration-time only: converts a seconds constant into packed MM:SS BCD.
    function automatic logic [15:0] sec_to_bcd(input int sec);
        int m;
        int s;
        m = sec / 60;
        s = sec % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

endpackage

// File: rtl/match_timer_display_seg_glyph.sv
// One seven-segment glyph: reports whether pixel (x,y) falls on a lit segment of digit.
module seg_glyph
    import match_timer_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic [9:0]         ox,
    input  logic [9:0]         oy,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic               hit
);

    localparam logic [10:0] GW     = 11'(GLYPH_W);
    localparam logic [10:0] GH     = 11'(GLYPH_H);
    localparam logic [10:0] GT     = 11'(SEG_T);
    localparam logic [10:0] MID_LO = 11'((GLYPH_H - SEG_T) / 2);
    localparam logic [10:0] MID_HI = 11'((GLYPH_H - SEG_T) / 2 + SEG_T);

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;
    logic [6:0]  segs;  // {a,b,c,d,e,f,g}
    logic        top, mid, bot, left, right, upper, lower;

    always_comb begin
        dx     = {1'b0, x} - {1'b0, ox};
        dy     = {1'b0, y} - {1'b0, oy};
        in_box = (x >= ox) && (y >= oy) && (dx < GW) && (dy < GH);
        case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        top   = dy < GT;
        mid   = (dy >= MID_LO) && (dy < MID_HI);
        bot   = dy >= (GH - GT);
        left  = dx < GT;
        right = dx >= (GW - GT);
        upper = dy < MID_HI;
        lower = dy >= MID_LO;
        hit   = in_box && ((segs[6] && top) || (segs[5] && right && upper) ||
                           (segs[4] && right && lower) || (segs[3] && bot) ||
                           (segs[2] && left && lower) || (segs[1] && left && upper) ||
                           (segs[0] && mid));
    end

endmodule

// File: rtl/match_timer_display.sv
// Match timer: BCD setpoint editing, 1 Hz countdown with expiry, and a registered MM:SS overlay.
module match_timer_display
    import match_timer_display_pkg::*;
#(
    parameter int CLK_HZ      = 25000000,
    parameter int DEFAULT_SEC = 60,
    parameter int STEP_SEC    = 10,
    parameter int MAX_SEC     = 5990,
    parameter int X0          = 235,
    parameter int Y0          = 240,
    parameter int PITCH       = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        dec,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        display,
    output logic        running,
    output logic        expired,
    output logic [15:0] time_bcd
);

    localparam int          PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF      = PW'(CLK_HZ / 2);
    localparam logic [15:0] DEF_BCD   = sec_to_bcd(DEFAULT_SEC);
    localparam logic [15:0] STEP_BCD  = sec_to_bcd(STEP_SEC);
    localparam logic [15:0] MAX_BCD   = sec_to_bcd(MAX_SEC);
    localparam logic [9:0]  X_MT  = 10'(X0);
    localparam logic [9:0]  X_MO  = 10'(X0 + PITCH);
    localparam logic [9:0]  X_ST  = 10'(X0 + 3 * PITCH);
    localparam logic [9:0]  X_SO  = 10'(X0 + 4 * PITCH);
    localparam logic [9:0]  Y_G   = 10'(Y0);
    localparam logic [9:0]  CX0   = 10'(X0 + 2 * PITCH + 5);
    localparam logic [9:0]  CX1   = 10'(X0 + 2 * PITCH + 10);
    localparam logic [9:0]  CYA0  = 10'(Y0 + 10);
    localparam logic [9:0]  CYA1  = 10'(Y0 + 15);
    localparam logic [9:0]  CYB0  = 10'(Y0 + 25);
    localparam logic [9:0]  CYB1  = 10'(Y0 + 30);

    // Digit-serial add/sub over MM:SS; the seconds-tens digit wraps at 6.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  t;
        logic [4:0]  rad;
        logic        c;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            rad = (i == 1) ? 5'd6 : 5'd10;
            t   = {1'b0, a[i*4+:4]} + {1'b0, b[i*4+:4]} + {4'd0, c};
            if (t >= rad) begin
                t = t - rad;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4+:4] = t[3:0];
        end
        return {c, r};
    endfunction

    function automatic logic [16:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  t;
        logic [4:0]  rad;
        logic        c;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            rad = (i == 1) ? 5'd6 : 5'd10;
            t   = {1'b0, a[i*4+:4]} - {1'b0, b[i*4+:4]} - {4'd0, c};
            if (t[4]) begin
                t = t + rad;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4+:4] = t[3:0];
        end
        return {c, r};
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   setpoint_q, setpoint_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          display_q, display_d;
    logic [16:0]   sp_up, sp_dn, cnt_dn;
    logic          tick, half, go, glyph_hit, colon_hit;
    logic [3:0]    hits;

    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        count_d    = count_q;
        presc_d    = presc_q;
        sp_up      = bcd_add(setpoint_q, STEP_BCD);
        sp_dn      = bcd_sub(setpoint_q, STEP_BCD);
        cnt_dn     = bcd_sub(count_q, 16'h0001);
        tick       = (presc_q == PRESC_MAX);
        go         = start && !stop;
        case (state_q)
            ST_SET: begin
                if (inc && !dec) begin
                    setpoint_d = (sp_up[16] || sp_up[15:0] > MAX_BCD) ? MAX_BCD : sp_up[15:0];
                end else if (dec && !inc) begin
                    setpoint_d = (sp_dn[16] || sp_dn[15:0] < STEP_BCD) ? STEP_BCD : sp_dn[15:0];
                end
                count_d = setpoint_d;
                if (go) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSED;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (cnt_dn[16] || cnt_dn[15:0] == 16'h0000) begin
                            count_d = '0;
                            state_d = ST_EXPIRED;
                        end else begin
                            count_d = cnt_dn[15:0];
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_SET;
                    count_d = setpoint_q;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Prescaler keeps running here purely to drive the blink.
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (go) begin
                    state_d = ST_SET;
                    count_d = setpoint_q;
                end
            end
        endcase
    end

    seg_glyph u_m_tens (.digit(count_q[15:12]), .ox(X_MT), .oy(Y_G), .x(x), .y(y), .hit(hits[3]));
    seg_glyph u_m_ones (.digit(count_q[11:8]),  .ox(X_MO), .oy(Y_G), .x(x), .y(y), .hit(hits[2]));
    seg_glyph u_s_tens (.digit(count_q[7:4]),   .ox(X_ST), .oy(Y_G), .x(x), .y(y), .hit(hits[1]));
    seg_glyph u_s_ones (.digit(count_q[3:0]),   .ox(X_SO), .oy(Y_G), .x(x), .y(y), .hit(hits[0]));

    always_comb begin
        half      = presc_q < HALF;
        glyph_hit = |hits;
        colon_hit = (x >= CX0) && (x < CX1) &&
                    (((y >= CYA0) && (y < CYA1)) || ((y >= CYB0) && (y < CYB1)));
        case (state_q)
            ST_RUN:     display_d = glyph_hit || (colon_hit && half);
            ST_EXPIRED: display_d = half && (glyph_hit || colon_hit);
            default:    display_d = glyph_hit || colon_hit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SET;
            setpoint_q <= DEF_BCD;
            count_q    <= DEF_BCD;
            presc_q    <= '0;
            display_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            display_q  <= display_d;
        end
    end

    assign display  = display_q;
    assign running  = (state_q == ST_RUN);
    assign expired  = (state_q == ST_EXPIRED);
    assign time_bcd = count_q;

endmodule
